// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode stage with one-entry output register and HALT FSM
// Optional register-busy scoreboard with hazard stalling: define DECODE_SCOREBOARD_EN.
module decode_stage (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] IN_INSTR,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [4:0]  SR1,
  output logic [4:0]  SR2,
  output logic [4:0]  DR,
  output logic        RegW,
  output logic [31:0] IMM,
  output logic [5:0]  OPC,
  output logic        ILL,
  output logic        HLT,
  input  logic        WB_EN,
  input  logic [4:0]  WB_DR
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t      state;
  logic [5:0]  d_opc;
  logic [4:0]  d_dr;
  logic        d_wr;
  logic        d_regw;
  logic        d_ill;
  logic        d_halt;
  logic        hazard;
  logic        accept;
  logic        consume;

  assign d_opc = IN_INSTR[31:26];

  always_comb begin
    d_dr   = 5'd0;
    d_wr   = 1'b0;
    d_ill  = 1'b0;
    d_halt = 1'b0;
    case (d_opc)
      OP_RTYPE: begin
        d_dr = IN_INSTR[15:11];
        d_wr = 1'b1;
      end
      OP_ADDI, OP_LW: begin
        d_dr = IN_INSTR[20:16];
        d_wr = 1'b1;
      end
      OP_SW, OP_BEQ: ;
      OP_HALT: d_halt = 1'b1;
      default: d_ill = 1'b1;
    endcase
  end

  // r0 is never a real write target, so it never claims a busy bit.
  assign d_regw = d_wr && (d_dr != 5'd0);

`ifdef DECODE_SCOREBOARD_EN
  logic [31:0] busy;
  logic [31:0] busy_nxt;
  logic        rd_sr1;
  logic        rd_sr2;

  assign rd_sr1 = !d_ill && !d_halt;
  assign rd_sr2 = (d_opc == OP_RTYPE) || (d_opc == OP_SW) || (d_opc == OP_BEQ);

  // Hazard looks only at registered busy bits; a same-cycle writeback is not bypassed.
  assign hazard = (rd_sr1 && busy[IN_INSTR[25:21]]) ||
                  (rd_sr2 && busy[IN_INSTR[20:16]]) ||
                  (d_regw && busy[d_dr]);

  // Set is applied after clear so a new writer of the same register wins.
  always_comb begin
    busy_nxt = busy;
    if (WB_EN && (WB_DR != 5'd0))
      busy_nxt[WB_DR] = 1'b0;
    if (accept && d_regw)
      busy_nxt[d_dr] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N)
      busy <= '0;
    else
      busy <= busy_nxt;
  end
`else
  logic unused_wb;

  assign hazard    = 1'b0;
  assign unused_wb = WB_EN ^ (^WB_DR);
`endif

  assign IN_READY = (state == RUN) && (!OUT_VALID || OUT_READY) && !hazard;
  assign accept   = IN_VALID && IN_READY;
  assign consume  = OUT_VALID && OUT_READY;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= RUN;
      OUT_VALID <= 1'b0;
      SR1       <= 5'd0;
      SR2       <= 5'd0;
      DR        <= 5'd0;
      RegW      <= 1'b0;
      IMM       <= 32'd0;
      OPC       <= 6'd0;
      ILL       <= 1'b0;
      HLT       <= 1'b0;
    end else begin
      if (accept) begin
        OUT_VALID <= 1'b1;
        OPC       <= d_opc;
        SR1       <= IN_INSTR[25:21];
        SR2       <= IN_INSTR[20:16];
        DR        <= d_dr;
        RegW      <= d_regw;
        IMM       <= {{16{IN_INSTR[15]}}, IN_INSTR[15:0]};
        ILL       <= d_ill;
      end else if (consume) begin
        OUT_VALID <= 1'b0;
      end
      case (state)
        RUN: begin
          if (accept && d_halt) begin
            state <= DRAIN;
            HLT   <= 1'b1;
          end
        end
        DRAIN: begin
          if (consume)
            state <= HALTED;
        end
        default: state <= HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized self-checking bench for decode_stage against a behavioural model
module tb_decode_stage;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] IN_INSTR;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [4:0]  SR1, SR2, DR;
  logic        RegW;
  logic [31:0] IMM;
  logic [5:0]  OPC;
  logic        ILL;
  logic        HLT;
  logic        WB_EN;
  logic [4:0]  WB_DR;

  decode_stage dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_INSTR(IN_INSTR),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .SR1(SR1), .SR2(SR2), .DR(DR), .RegW(RegW), .IMM(IMM), .OPC(OPC),
    .ILL(ILL), .HLT(HLT), .WB_EN(WB_EN), .WB_DR(WB_DR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [5:0]  opc;
    logic [4:0]  sr1;
    logic [4:0]  sr2;
    logic [4:0]  dr;
    logic        regw;
    logic [31:0] imm;
    logic        ill;
    logic        halt;
    logic        rd1;
    logic        rd2;
  } dec_t;

  int    n_cmp = 0;
  int    n_err = 0;
  bit    chk_en = 0;
  bit    m_busy [32];
  bit    m_ov;
  bit    m_halt;
  dec_t  m_ent;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic dec_t dec(input logic [31:0] i);
    dec_t d;
    d      = '0;
    d.opc  = i[31:26];
    d.sr1  = i[25:21];
    d.sr2  = i[20:16];
    d.imm  = {{16{i[15]}}, i[15:0]};
    case (d.opc)
      6'h00:        begin d.dr = i[15:11]; d.regw = 1; d.rd1 = 1; d.rd2 = 1; end
      6'h08, 6'h23: begin d.dr = i[20:16]; d.regw = 1; d.rd1 = 1; end
      6'h2B, 6'h04: begin d.rd1 = 1; d.rd2 = 1; end
      6'h3F:        d.halt = 1;
      default:      d.ill = 1;
    endcase
    if (d.dr == 0) d.regw = 0;
    return d;
  endfunction

  function automatic bit exp_ready();
    dec_t d;
    bit   haz;
    d   = dec(IN_INSTR);
    haz = 0;
`ifdef DECODE_SCOREBOARD_EN
    if (d.rd1 && m_busy[d.sr1]) haz = 1;
    if (d.rd2 && m_busy[d.sr2]) haz = 1;
    if (d.regw && m_busy[d.dr]) haz = 1;
`endif
    return !m_halt && (!m_ov || OUT_READY) && !haz;
  endfunction

  // Advances the model across one rising edge using the inputs the DUT sees at that edge.
  task automatic model_step();
    dec_t d;
    bit   acc, cons;
    if (!RST_N) begin
      m_ov   = 0;
      m_halt = 0;
      m_ent  = '0;
      foreach (m_busy[k]) m_busy[k] = 0;
      return;
    end
    d    = dec(IN_INSTR);
    acc  = IN_VALID && exp_ready();
    cons = m_ov && OUT_READY;
    if (WB_EN && WB_DR != 0) m_busy[WB_DR] = 0;
    if (acc && d.regw) m_busy[d.dr] = 1;
    if (acc) begin
      m_ent = d;
      m_ov  = 1;
      if (d.halt) m_halt = 1;
    end else if (cons) begin
      m_ov = 0;
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input bit ordy);
    IN_VALID  = v;
    IN_INSTR  = ins;
    OUT_READY = ordy;
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("out_valid", OUT_VALID, m_ov);
      chk("hlt", HLT, m_halt);
      chk("in_ready", IN_READY, exp_ready());
      chk("opc", OPC, m_ent.opc);
      chk("sr1", SR1, m_ent.sr1);
      chk("sr2", SR2, m_ent.sr2);
      chk("dr", DR, m_ent.dr);
      chk("regw", RegW, m_ent.regw);
      chk("imm", IMM, m_ent.imm);
      chk("ill", ILL, m_ent.ill);
    end
  end

  function automatic logic [31:0] rnd_instr();
    int          r;
    logic [5:0]  op;
    logic [31:0] w;
    r = $urandom_range(0, 99);
    if      (r < 25) op = 6'h00;
    else if (r < 40) op = 6'h08;
    else if (r < 50) op = 6'h23;
    else if (r < 62) op = 6'h2B;
    else if (r < 72) op = 6'h04;
    else if (r < 74) op = 6'h3F;
    else             op = 6'($urandom_range(0, 63));
    w = $urandom;
    w[31:26] = op;
    w[25:21] = 5'($urandom_range(0, 7));
    w[20:16] = 5'($urandom_range(0, 7));
    w[15:11] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  initial begin
    RST_N = 0; WB_EN = 0; WB_DR = 0;
    drive(0, 32'h0, 0);
    step();
    chk_en = 1;
    step();
    RST_N = 1;
    @(negedge CLK);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_in_ready", IN_READY, 1);
    chk("rst_hlt", HLT, 0);
    chk("rst_fields", {OPC, SR1, SR2, DR, RegW, ILL}, 0);
    chk("rst_imm", IMM, 0);

    step();
    drive(1, 32'h012A4020, 1);
    step();
    drive(1, 32'h01020820, 1);
    @(negedge CLK);
    chk("rtype_valid", OUT_VALID, 1);
    chk("rtype_regs", {SR1, SR2, DR}, {5'd9, 5'd10, 5'd8});
    chk("rtype_regw", RegW, 1);
`ifdef DECODE_SCOREBOARD_EN
    chk("raw_stall0", IN_READY, 0);
    step();
    @(negedge CLK);
    chk("raw_stall1", IN_READY, 0);
    step();
    WB_EN = 1; WB_DR = 8;
    @(negedge CLK);
    chk("raw_no_bypass", IN_READY, 0);
    step();
    WB_EN = 0;
    @(negedge CLK);
    chk("raw_release", IN_READY, 1);
    step();
`else
    chk("raw_no_stall", IN_READY, 1);
    step();
`endif

    drive(1, 32'h2128FFFF, 1);
    step();
    drive(1, 32'h21200005, 1);
    @(negedge CLK);
    chk("addi_regs", {SR1, DR}, {5'd9, 5'd8});
    chk("addi_imm", IMM, 32'hFFFFFFFF);
    chk("addi_regw", RegW, 1);
    step();
    drive(0, 32'h0, 1);
    @(negedge CLK);
    chk("addi_r0_regw", RegW, 0);
    chk("addi_r0_imm", IMM, 32'h5);

    step();
    drive(1, 32'hF8A51234, 1);
    step();
    drive(1, 32'hAC640010, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("bp_valid", OUT_VALID, 1);
      chk("bp_opc_ill", {OPC, ILL, RegW}, {6'h3E, 1'b1, 1'b0});
      chk("bp_imm", IMM, 32'h1234);
      chk("bp_in_ready", IN_READY, 0);
      step();
    end
    OUT_READY = 1;
    @(negedge CLK);
    chk("bp_release", IN_READY, 1);
    step();
    drive(0, 32'h0, 1);
    @(negedge CLK);
    chk("sw_out", {OUT_VALID, OPC, RegW, DR}, {1'b1, 6'h2B, 1'b0, 5'd0});

    step();
    drive(1, 32'hFC000000, 1);
    step();
    drive(1, 32'h012A4020, 1);
    @(negedge CLK);
    chk("halt_hlt", HLT, 1);
    chk("halt_in_ready", IN_READY, 0);
    chk("halt_out", {OUT_VALID, OPC}, {1'b1, 6'h3F});
    step();
    @(negedge CLK);
    chk("halt_consumed", OUT_VALID, 0);
    repeat (4) step();
    @(negedge CLK);
    chk("halted_idle", {OUT_VALID, IN_READY, HLT}, {1'b0, 1'b0, 1'b1});
    step();
    RST_N = 0;
    step();
    RST_N = 1;
    drive(0, 32'h0, 0);
    @(negedge CLK);
    chk("rerst_ready", IN_READY, 1);
    chk("rerst_outs", {OUT_VALID, HLT, OPC, SR1, SR2, DR, RegW, ILL}, 0);
    chk("rerst_imm", IMM, 0);

    for (int c = 0; c < 4000; c++) begin
      step();
      RST_N     = !((m_halt && $urandom_range(0, 15) == 0) || $urandom_range(0, 299) == 0);
      IN_VALID  = ($urandom_range(0, 9) < 7);
      IN_INSTR  = rnd_instr();
      OUT_READY = ($urandom_range(0, 3) != 0);
      WB_EN     = ($urandom_range(0, 9) < 3);
      WB_DR     = 5'($urandom_range(0, 7));
    end
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
